periph_bridge: RTL and testbench



---
 rtl/periph_bridge.sv | 181 ++++++++++++++++++
 tb/tb_periph_bridge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bridge.sv
// rtl/periph_bridge.sv - CPU bus to multi-channel peripheral register bridge with timeout and open-bus latch
module periph_bridge #(
  parameter int                ADDR_N   = 16,
  parameter int                DATA_N   = 8,
  parameter int                PERIPH_N = 3,
  parameter int                CHANNELS = 4,
  parameter logic [ADDR_N-1:0] BASE     = 16'h4000,
  parameter int                TIMEOUT  = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req,
  input  logic                       we,
  input  logic [ADDR_N-1:0]          addr,
  input  logic [DATA_N-1:0]          wdata,
  output logic [DATA_N-1:0]          rdata,
  output logic                       ack,
  output logic                       err,
  output logic                       busy,
  output logic [CHANNELS-1:0]        ch_sel,
  output logic                       ch_we,
  output logic [PERIPH_N-1:0]        ch_addr,
  output logic [DATA_N-1:0]          ch_wdata,
  input  logic [CHANNELS*DATA_N-1:0] ch_rdata,
  input  logic [CHANNELS-1:0]        ch_ready
);

  localparam int                CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [ADDR_N:0]   LIMIT    = {1'b0, BASE} + (ADDR_N+1)'(CHANNELS << PERIPH_N);
  localparam logic [7:0]        CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t                state_q, state_n;
  logic                  we_q, we_n;
  logic [CHANNELS-1:0]   sel_n;
  logic                  ch_we_n;
  logic [PERIPH_N-1:0]   ch_addr_n;
  logic [DATA_N-1:0]     ch_wdata_n;
  logic [DATA_N-1:0]     rdata_n;
  logic [DATA_N-1:0]     open_bus, open_bus_n;
  logic                  ack_n, err_n, busy_n;
  logic [7:0]            cnt, cnt_n;

  logic [ADDR_N-1:0]     offset;
  logic [CH_W-1:0]       idx;
  logic                  mapped;
  logic                  ready_hit;
  logic [DATA_N-1:0]     sel_rdata;
  logic                  fin, fin_ok;

  assign offset    = addr - BASE;
  assign idx       = offset[PERIPH_N +: CH_W];
  assign mapped    = (addr >= BASE) && ({1'b0, addr} < LIMIT);
  // Only the latched channel's ready counts; ch_sel is one-hot while an access is open.
  assign ready_hit = |(ch_ready & ch_sel);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel[i]) sel_rdata = sel_rdata | ch_rdata[i*DATA_N +: DATA_N];
    end
  end

  always_comb begin
    state_n    = state_q;
    we_n       = we_q;
    sel_n      = ch_sel;
    ch_we_n    = ch_we;
    ch_addr_n  = ch_addr;
    ch_wdata_n = ch_wdata;
    rdata_n    = rdata;
    open_bus_n = open_bus;
    ack_n      = 1'b0;
    err_n      = 1'b0;
    cnt_n      = cnt;
    fin        = 1'b0;
    fin_ok     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_n = we;
          if (mapped) begin
            state_n    = ACCESS;
            sel_n      = CHANNELS'(1) << idx;
            ch_we_n    = we;
            ch_addr_n  = addr[PERIPH_N-1:0];
            ch_wdata_n = wdata;
          end else begin
            state_n = RESP;
            ack_n   = 1'b1;
            err_n   = 1'b1;
            if (we) begin
              open_bus_n = wdata;
              rdata_n    = wdata;
            end else begin
              rdata_n = open_bus;
            end
          end
        end
      end
      ACCESS: begin
        if (ready_hit) begin
          fin    = 1'b1;
          fin_ok = 1'b1;
        end else begin
          state_n = WAIT;
          cnt_n   = 8'd0;
        end
      end
      WAIT: begin
        if (ready_hit) begin
          fin    = 1'b1;
          fin_ok = 1'b1;
        end else if (cnt == CNT_LAST) begin
          fin = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Writes always refresh the open bus; reads only when the peripheral answered.
    if (fin) begin
      state_n = RESP;
      ack_n   = 1'b1;
      err_n   = !fin_ok;
      sel_n   = '0;
      ch_we_n = 1'b0;
      if (we_q) begin
        open_bus_n = ch_wdata;
        rdata_n    = ch_wdata;
      end else if (fin_ok) begin
        open_bus_n = sel_rdata;
        rdata_n    = sel_rdata;
      end else begin
        rdata_n = open_bus;
      end
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      ch_sel   <= '0;
      ch_we    <= 1'b0;
      ch_addr  <= '0;
      ch_wdata <= '0;
      rdata    <= '0;
      open_bus <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      cnt      <= 8'd0;
    end else begin
      state_q  <= state_n;
      we_q     <= we_n;
      ch_sel   <= sel_n;
      ch_we    <= ch_we_n;
      ch_addr  <= ch_addr_n;
      ch_wdata <= ch_wdata_n;
      rdata    <= rdata_n;
      open_bus <= open_bus_n;
      ack      <= ack_n;
      err      <= err_n;
      busy     <= busy_n;
      cnt      <= cnt_n;
    end
  end

endmodule

// File: tb/tb_periph_bridge.sv
// tb/tb_periph_bridge.sv - self-checking bench for periph_bridge
module tb_periph_bridge;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ack;
  logic        err;
  logic        busy;
  logic [3:0]  ch_sel;
  logic        ch_we;
  logic [2:0]  ch_addr;
  logic [7:0]  ch_wdata;
  logic [31:0] ch_rdata;
  logic [3:0]  ch_ready;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  ob_m;

  typedef struct {
    bit          w;
    logic [15:0] a;
    logic [7:0]  wd;
    int          d;
    logic [7:0]  rd;
    int          lat;
    bit          e;
    logic [7:0]  rdx;
    logic [3:0]  sel;
    int          selc;
    logic [2:0]  ca;
  } vec_t;

  always #5 clk = ~clk;

  periph_bridge #(
    .ADDR_N(16), .DATA_N(8), .PERIPH_N(3), .CHANNELS(4), .BASE(16'h4000), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy),
    .ch_sel(ch_sel), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_rdata(ch_rdata), .ch_ready(ch_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: window 0x4000..0x401F, 8 registers per channel, ready after d
  // selected cycles succeeds while d < TO, otherwise the access times out.
  task automatic model(inout vec_t v);
    bit m;
    bit ok;
    m = (v.a >= 16'h4000) && (v.a < 16'h4020);
    v.ca = v.a[2:0];
    if (!m) begin
      v.lat = 1; v.e = 1'b1; v.sel = 4'd0; v.selc = 0;
    end else begin
      ok     = (v.d <= TO - 1);
      v.sel  = 4'(1 << ((v.a - 16'h4000) / 8));
      v.lat  = ok ? 2 + v.d : 2 + TO;
      v.e    = !ok;
      v.selc = ok ? v.d + 1 : TO + 1;
    end
    if (v.w) ob_m = v.wd;
    else if (m && !v.e) ob_m = v.rd;
    v.rdx = ob_m;
  endtask

  task automatic run_txn(input bit w, input logic [15:0] a, input logic [7:0] wd,
                         input int d, input logic [7:0] rd,
                         output int lat, output bit e, output logic [7:0] rdv,
                         output logic [3:0] selv, output int selc, output bit wev,
                         output logic [2:0] av, output logic [7:0] wdv,
                         output bit bad, output bit post_bad);
    int c;
    lat = -1; e = 1'b0; rdv = 8'h00; selv = 4'h0; selc = 0; wev = 1'b0;
    av = 3'd0; wdv = 8'h00; bad = 1'b0; post_bad = 1'b0;
    ch_rdata = $urandom;
    if (a >= 16'h4000 && a < 16'h4020) begin
      c = int'(a - 16'h4000) / 8;
      ch_rdata[c*8 +: 8] = rd;
    end
    req = 1'b1; we = w; addr = a; wdata = wd; ch_ready = 4'h0;
    for (int k = 1; k <= 300 && lat < 0; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (!busy) bad = 1'b1;
      if (ch_sel != 4'h0) begin
        selc++;
        if (selc == 1) begin
          selv = ch_sel; wev = ch_we; av = ch_addr; wdv = ch_wdata;
        end else if (ch_sel !== selv || ch_we !== wev || ch_addr !== av || ch_wdata !== wdv) begin
          bad = 1'b1;
        end
        ch_ready = (selc == d + 1) ? (ch_sel | 4'($urandom)) : (4'($urandom) & ~ch_sel);
      end else begin
        ch_ready = 4'h0;
      end
      if (ack) begin
        lat = k; e = err; rdv = rdata;
      end
    end
    ch_ready = 4'h0;
    @(negedge clk);
    if (ack || busy || ch_sel != 4'h0) post_bad = 1'b1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    int         lat, selc;
    bit         e, wev, bad, post_bad;
    logic [7:0] rdv, wdv;
    logic [3:0] selv;
    logic [2:0] av;
    run_txn(v.w, v.a, v.wd, v.d, v.rd, lat, e, rdv, selv, selc, wev, av, wdv, bad, post_bad);
    chk({tag, ".lat"}, lat, v.lat);
    chk({tag, ".err"}, 32'(e), 32'(v.e));
    if (!v.w) chk({tag, ".rdata"}, 32'(rdv), 32'(v.rdx));
    chk({tag, ".sel"}, 32'(selv), 32'(v.sel));
    chk({tag, ".sel_cycles"}, selc, v.selc);
    if (v.selc > 0) begin
      chk({tag, ".ch_we"}, 32'(wev), 32'(v.w));
      chk({tag, ".ch_addr"}, 32'(av), 32'(v.ca));
      if (v.w) chk({tag, ".ch_wdata"}, 32'(wdv), 32'(v.wd));
    end
    chk({tag, ".steady"}, 32'(bad), 32'd0);
    chk({tag, ".idle_after"}, 32'(post_bad), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[10];
    vec_t       v;
    logic [3:0] sel_tr[1:8];
    logic [7:0] ack_tr, busy_tr, rd1, rd2;
    logic [15:0] bnd[4];
    int         nack, flag, r;

    tbl[0] = '{1, 16'h4009, 8'hA5, 0,   8'h00, 2,  0, 8'h00, 4'b0010, 1,  3'd1};
    tbl[1] = '{0, 16'h401A, 8'h00, 4,   8'h3C, 6,  0, 8'h3C, 4'b1000, 5,  3'd2};
    tbl[2] = '{0, 16'h4010, 8'h00, 99,  8'h5A, 17, 1, 8'h3C, 4'b0100, 16, 3'd0};
    tbl[3] = '{1, 16'h3FFF, 8'h77, 0,   8'h00, 1,  1, 8'h00, 4'b0000, 0,  3'd0};
    tbl[4] = '{0, 16'h4020, 8'h00, 0,   8'h00, 1,  1, 8'h77, 4'b0000, 0,  3'd0};
    tbl[5] = '{0, 16'h4000, 8'h00, 0,   8'h11, 2,  0, 8'h11, 4'b0001, 1,  3'd0};
    tbl[6] = '{0, 16'h401F, 8'h00, 14,  8'hE7, 16, 0, 8'hE7, 4'b1000, 15, 3'd7};
    tbl[7] = '{0, 16'h4018, 8'h00, 200, 8'h00, 17, 1, 8'hE7, 4'b1000, 16, 3'd0};
    tbl[8] = '{1, 16'h4012, 8'hC3, 200, 8'h00, 17, 1, 8'h00, 4'b0100, 16, 3'd2};
    tbl[9] = '{0, 16'hFFFF, 8'h00, 0,   8'h00, 1,  1, 8'hC3, 4'b0000, 0,  3'd0};
    bnd[0] = 16'h3FFF; bnd[1] = 16'h4000; bnd[2] = 16'h401F; bnd[3] = 16'h4020;

    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 8'h0;
    ch_ready = 4'h0; ch_rdata = 32'h0;
    #1;
    chk("por.outputs", {19'd0, ack, err, busy, ch_sel, ch_we, ch_addr}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Fill rdata/open bus so the mid-transaction reset has something to clear.
    v = '{0, 16'h4001, 8'h00, 0, 8'h99, 2, 0, 8'h99, 4'b0001, 1, 3'd1};
    apply(v, "pre");

    req = 1'b1; we = 1'b0; addr = 16'h4013; wdata = 8'h5B; ch_ready = 4'h0;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst.pre_sel", 32'(ch_sel), 32'(4'b0100));
    chk("rst.pre_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst.ch_sel", 32'(ch_sel), 32'd0);
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.rdata", 32'(rdata), 32'd0);
    chk("rst.ch_we", 32'(ch_we), 32'd0);
    chk("rst.ch_addr", 32'(ch_addr), 32'd0);
    chk("rst.ch_wdata", 32'(ch_wdata), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    flag = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack || busy) flag = 1;
    end
    chk("rst.no_ack", flag, 0);
    v = '{0, 16'h5000, 8'h00, 0, 8'h00, 1, 1, 8'h00, 4'b0000, 0, 3'd0};
    apply(v, "rst_read");

    for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("vec%0d", i));
    ob_m = 8'hC3;

    ch_rdata = 32'h0000_B2A1; ch_ready = 4'hF;
    req = 1'b1; we = 1'b0; addr = 16'h4000;
    nack = 0; ack_tr = 8'h00; busy_tr = 8'h00; rd1 = 8'h00; rd2 = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      sel_tr[k] = ch_sel; ack_tr[k-1] = ack; busy_tr[k-1] = busy;
      if (ack) begin
        nack++;
        if (nack == 1) rd1 = rdata; else rd2 = rdata;
      end
      if (k == 1) addr = 16'h4008;
      if (k == 4) req = 1'b0;
    end
    ch_ready = 4'h0;
    chk("b2b.sel1", 32'(sel_tr[1]), 32'(4'b0001));
    chk("b2b.gap", 32'({sel_tr[2], sel_tr[3]}), 32'd0);
    chk("b2b.sel2", 32'(sel_tr[4]), 32'(4'b0010));
    chk("b2b.ack_count", nack, 2);
    chk("b2b.ack_trace", 32'(ack_tr), 32'(8'b0001_0010));
    chk("b2b.busy_trace", 32'(busy_tr), 32'(8'b0001_1011));
    chk("b2b.rdata1", 32'(rd1), 32'(8'hA1));
    chk("b2b.rdata2", 32'(rd2), 32'(8'hB2));
    ob_m = 8'hB2;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      v.w  = 1'($urandom_range(0, 1));
      r    = int'($urandom_range(0, 3));
      if (r == 0)      v.a = 16'($urandom);
      else if (r == 1) v.a = bnd[$urandom_range(0, 3)];
      else             v.a = 16'h4000 + 16'($urandom_range(0, 31));
      v.d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO + 1, TO + 5))
                                         : int'($urandom_range(0, TO - 1));
      v.wd = 8'($urandom);
      v.rd = 8'($urandom);
      model(v);
      apply(v, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
